// File: rtl/parity_pkg.sv
// Shared definitions for the parity serial link (transmitter and receive-side checker).
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int FRAME_BITS         = DEFAULT_DATA_WIDTH + 3;

    // Start + data + parity + stop, for widths other than the default.
    function automatic int frame_bits(input int data_width);
        return data_width + 3;
    endfunction

endpackage

// File: rtl/parity_generator.sv
// Even-parity generator: output is the XOR of all data bits.
module parity_generator #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_parity
);

    assign o_parity = ^i_data;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, data LSB first, even parity, stop bit.
// Optional macro PARITY_ERR_INJECT_EN adds err_inject to invert one frame's parity.
//
// state  | meaning
// IDLE   | line high, in_ready asserted, waiting for a word
// START  | driving the start bit (0)
// DATA   | driving shift register LSB, one bit per bit period
// PARITY | driving the latched parity bit
// STOP   | driving the stop bit (1); frame_done on its last cycle
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PARITY_ERR_INJECT_EN
    input  logic                  err_inject,
`endif
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_PENULT = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [CW-1:0]         r_clk_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_parity;
    logic                  w_parity_latch;
    logic                  w_bit_end;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_shift_next;

    parity_generator #(.DATA_WIDTH(DATA_WIDTH)) u_parity_gen (
        .i_data   (in_data),
        .o_parity (w_parity)
    );

`ifdef PARITY_ERR_INJECT_EN
    assign w_parity_latch = w_parity ^ err_inject;
`else
    assign w_parity_latch = w_parity;
`endif

    assign w_bit_end    = (r_clk_cnt == CLK_LAST);
    assign w_accept     = in_valid && (r_state == IDLE);
    assign w_shift_next = r_shift >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE) begin
                r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (w_accept) begin
                        r_shift  <= in_data;
                        r_parity <= w_parity_latch;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_tx      <= r_parity;
                            r_state   <= PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    // Registered pulse, so raise it one cycle ahead to land on the last stop cycle.
                    if (r_clk_cnt == CLK_PENULT) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
